fp_mul_arbiter: RTL and testbench
=================================

Name: fp_mul_arbiter

Overview:
- Shares one combinational single-precision FP multiplier between NUM_REQ requesters.
- Each requester presents an operand pair with a valid/ready handshake. The block grants requesters round-robin, drives the shared multiplier from registered operands, captures the product, and returns it tagged with the requester index.
- Sits between the requester cores and the shared multiplier instance in the FP multiplier full system.

Parameters:
- NUM_REQ, 4: number of requesters, 2..16.
- ID_W, 2: width of the requester index; must equal clog2(NUM_REQ).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester operand pair valid.
- req_ready  output  NUM_REQ  per-requester grant; one-hot or zero.
- req_a  input  NUM_REQ*32  operand A, packed; requester i occupies bits [32i+31:32i].
- req_b  input  NUM_REQ*32  operand B, packed the same way.
- mul_a  output  32  operand A to the shared multiplier.
- mul_b  output  32  operand B to the shared multiplier.
- mul_result  input  32  product from the shared multiplier (combinational from mul_a/mul_b).
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response consumer ready.
- rsp_id  output  ID_W  index of the requester that issued the operation.
- rsp_result  output  32  product.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset values: state=IDLE, rr_ptr=0, req_ready=0, rsp_valid=0, rsp_id=0, rsp_result=0, mul_a=0, mul_b=0, busy=0.
- FSM: IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - If any req_valid is set, pick the first valid index starting at rr_ptr and wrapping modulo NUM_REQ; call it g.
  - Assert req_ready[g] combinationally in this cycle; the transfer completes this cycle.
  - Latch req_a[g]/req_b[g] into op_a/op_b and latch g into id_q; go to EXEC.
  - rr_ptr <= (g+1) mod NUM_REQ.
  - If no req_valid is set, stay in IDLE; rr_ptr is unchanged.
- req_ready is asserted only in IDLE, and only for the granted index.
- mul_a/mul_b are driven from op_a/op_b, which are stable from EXEC until the next grant.
- EXEC: rsp_result <= mul_result; rsp_id <= id_q; rsp_valid <= 1; go to RESP.
- RESP:
  - Hold rsp_valid, rsp_id and rsp_result stable until rsp_ready=1.
  - On the cycle rsp_valid&&rsp_ready, clear rsp_valid and go to IDLE.
  - No new grant is made in RESP, even if rsp_ready is high.
- Latency and throughput: grant at cycle T, rsp_valid rises at T+2. Back-to-back throughput is 1 op per 3 cycles when rsp_ready is tied high.
- Fairness: a continuously asserted requester is granted within NUM_REQ grants.
- The product is passed through unaltered, so the multiplier's zero handling and truncation (no rounding) apply.
- Requesters may deassert req_valid before being granted; the arbiter does not latch requests.
- rst asserted in EXEC or RESP: the in-flight operation is discarded, no response is produced, and rr_ptr returns to 0.

Optional Feature:
- Macro FP_MUL_ARB_SPECIAL_EN.
- When defined, in EXEC, if either operand exponent is 8'hFF the captured result is overridden:
  - any NaN operand (exp=FF, mantissa≠0), or Inf times zero (other operand[30:0]=0): rsp_result = 32'h7FC00000;
  - otherwise (Inf times finite nonzero, or Inf times Inf): rsp_result = {a[31]^b[31], 8'hFF, 23'd0}.
- When not defined, mul_result is passed through unmodified. Timing and handshakes are identical in both builds.

Decomposition:
- Package fp_mul_arb_pkg holds:
  - FP_W=32, EXP_MAX=8'hFF, QNAN=32'h7FC00000;
  - state typedef enum {IDLE, EXEC, RESP};
  - function fp_is_nan(x) and function fp_is_inf(x).
- One sub-module, rr_arbiter: combinational round-robin priority pick. Inputs are a req vector and ptr; outputs are a one-hot grant, the grant index and any_valid.
- The FSM and datapath registers stay in fp_mul_arbiter.

Test Plan:
- Single request: requester 1 sends a=0x40000000, b=0x40400000; rsp_ready=1 -> req_ready[1] pulses at T; at T+2 rsp_valid=1, rsp_id=1, rsp_result=0x40C00000.
- Round-robin: all four req_valid held high with distinct operands (2.0×3.0, 1.5×1.5, −2.0×3.0, 0×5.0) -> grants in order 0,1,2,3,0. Results are 0x40C00000, 0x40100000, 0xC0C00000 and 0x00000000.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_valid, rsp_id and rsp_result held stable, no req_ready pulses. Release -> one-cycle handshake, then a new grant in the next IDLE cycle.
- Pointer wrap: only requester 3 valid, then only requester 0 -> rr_ptr goes 3→0 and the grant to 0 occurs in the first IDLE cycle.
- Reset mid-operation: assert rst in EXEC -> next cycle rsp_valid=0, busy=0, rr_ptr=0, and no response is ever produced for the dropped operation.
- Special values, FP_MUL_ARB_SPECIAL_EN defined: 0x7F800000×0x00000000 -> 0x7FC00000; 0xFF800000×0x40000000 -> 0xFF800000. Same stimulus without the macro -> raw multiplier output passed through.

Source files
------------

// File: rtl/fp_mul_arb_pkg.sv
// Shared definitions for the FP multiplier arbiter: state encoding,
// IEEE-754 single-precision field constants and special-value helpers.
// The helpers are used by fp_mul_arbiter when FP_MUL_ARB_SPECIAL_EN is defined.
package fp_mul_arb_pkg;

   localparam int          FP_W    = 32;
   localparam logic [7:0]  EXP_MAX = 8'hFF;
   localparam logic [31:0] QNAN    = 32'h7FC0_0000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   // NaN: all-ones exponent with a non-zero mantissa
   function automatic logic fp_is_nan(input logic [FP_W-1:0] x);
      return (x[30:23] == EXP_MAX) && (x[22:0] != 23'd0);
   endfunction

   // Infinity: all-ones exponent with a zero mantissa
   function automatic logic fp_is_inf(input logic [FP_W-1:0] x);
      return (x[30:23] == EXP_MAX) && (x[22:0] == 23'd0);
   endfunction

endpackage

// File: rtl/fp_mul_arbiter_rr_arbiter.sv
// Combinational round-robin priority pick. Starting at i_ptr and wrapping
// modulo NUM_REQ, the first asserted request wins. Produces a one-hot grant,
// the binary index of the winner and a flag telling whether anything won.
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [ID_W-1:0]    i_ptr,
   output logic [NUM_REQ-1:0] o_grant,
   output logic [ID_W-1:0]    o_idx,
   output logic               o_any
);

   // Walk priority positions from the pointer outward; first valid requester wins
   always_comb begin
      logic w_found;
      w_found = 1'b0;
      o_grant = '0;
      o_idx   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         for (int j = 0; j < NUM_REQ; j++) begin
            if (!w_found && i_req[j] && (j == ((int'(i_ptr) + k) % NUM_REQ))) begin
               w_found    = 1'b1;
               o_grant[j] = 1'b1;
               o_idx      = ID_W'(j);
            end
         end
      end
      o_any = w_found;
   end

endmodule

// File: rtl/fp_mul_arbiter.sv
// Round-robin arbiter sharing one combinational single-precision multiplier
// among NUM_REQ requesters. One operation at a time: grant in IDLE, the
// multiplier settles during EXEC, the tagged product is offered in RESP.
// Optional build macro FP_MUL_ARB_SPECIAL_EN: override the captured product
// for Inf/NaN operands (NaN or Inf*0 -> quiet NaN, else signed Inf).
module fp_mul_arbiter
   import fp_mul_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_REQ-1:0]      req_valid,
   output logic [NUM_REQ-1:0]      req_ready,
   input  logic [NUM_REQ*32-1:0]   req_a,
   input  logic [NUM_REQ*32-1:0]   req_b,
   output logic [31:0]             mul_a,
   output logic [31:0]             mul_b,
   input  logic [31:0]             mul_result,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [ID_W-1:0]         rsp_id,
   output logic [31:0]             rsp_result,
   output logic                    busy
);

   state_t               r_state;
   logic [ID_W-1:0]      r_rr_ptr;
   logic [31:0]          r_op_a;
   logic [31:0]          r_op_b;
   logic [ID_W-1:0]      r_id_q;
   logic                 r_rsp_valid;
   logic [ID_W-1:0]      r_rsp_id;
   logic [31:0]          r_rsp_result;

   logic [NUM_REQ-1:0]   w_grant;
   logic [ID_W-1:0]      w_idx;
   logic                 w_any;
   logic [ID_W-1:0]      w_next_ptr;
   logic [31:0]          w_sel_a;
   logic [31:0]          w_sel_b;
   logic [31:0]          w_capture;

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_rr (
      .i_req   (req_valid),
      .i_ptr   (r_rr_ptr),
      .o_grant (w_grant),
      .o_idx   (w_idx),
      .o_any   (w_any)
   );

   // Pointer moves one past the winner, wrapping for non-power-of-two counts
   always_comb begin
      w_next_ptr = (w_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
   end

   // Operand mux driven by the one-hot grant
   always_comb begin
      w_sel_a = '0;
      w_sel_b = '0;
      for (int j = 0; j < NUM_REQ; j++) begin
         if (w_grant[j]) begin
            w_sel_a = req_a[32*j +: 32];
            w_sel_b = req_b[32*j +: 32];
         end
      end
   end

   // Product to capture in EXEC, optionally with IEEE special-value override
   always_comb begin
      w_capture = mul_result;
`ifdef FP_MUL_ARB_SPECIAL_EN
      if (fp_is_nan(r_op_a) || fp_is_inf(r_op_a) ||
          fp_is_nan(r_op_b) || fp_is_inf(r_op_b)) begin
         if (fp_is_nan(r_op_a) || fp_is_nan(r_op_b) ||
             (r_op_a[30:0] == 31'd0) || (r_op_b[30:0] == 31'd0)) begin
            w_capture = QNAN;
         end else begin
            w_capture = {r_op_a[31] ^ r_op_b[31], EXP_MAX, 23'd0};
         end
      end
`endif
   end

   // Control FSM and datapath registers: grant, multiply, respond
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= IDLE;
         r_rr_ptr     <= '0;
         r_op_a       <= '0;
         r_op_b       <= '0;
         r_id_q       <= '0;
         r_rsp_valid  <= 1'b0;
         r_rsp_id     <= '0;
         r_rsp_result <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_any) begin
                  r_op_a   <= w_sel_a;
                  r_op_b   <= w_sel_b;
                  r_id_q   <= w_idx;
                  r_rr_ptr <= w_next_ptr;
                  r_state  <= EXEC;
               end
            end
            EXEC: begin
               r_rsp_result <= w_capture;
               r_rsp_id     <= r_id_q;
               r_rsp_valid  <= 1'b1;
               r_state      <= RESP;
            end
            RESP: begin
               if (rsp_ready) begin
                  r_rsp_valid <= 1'b0;
                  r_state     <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign req_ready  = (r_state == IDLE) ? w_grant : '0;
   assign mul_a      = r_op_a;
   assign mul_b      = r_op_b;
   assign rsp_valid  = r_rsp_valid;
   assign rsp_id     = r_rsp_id;
   assign rsp_result = r_rsp_result;
   assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Bench for fp_mul_arbiter: a behavioural FP multiplier feeds mul_result,
// a transaction-level model predicts grants and pushes expected responses
// into a queue, and an independent monitor checks every offered response.
// Build with FP_MUL_ARB_SPECIAL_EN defined to match the special-value RTL.
module tb_fp_mul_arbiter;

   localparam int N    = 4;
   localparam int ID_W = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic [N-1:0]      req_valid;
   logic [N-1:0]      req_ready;
   logic [N*32-1:0]   req_a;
   logic [N*32-1:0]   req_b;
   logic [31:0]       mul_a;
   logic [31:0]       mul_b;
   logic [31:0]       mul_result;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [ID_W-1:0]   rsp_id;
   logic [31:0]       rsp_result;
   logic              busy;

   logic [31:0]       va [N];
   logic [31:0]       vb [N];
   logic [31:0]       last_res [N];

   int                n_tests = 0;
   int                n_fail  = 0;

   typedef struct packed {
      logic [ID_W-1:0] id;
      logic [31:0]     res;
   } rsp_t;
   rsp_t exp_q [$];

   // model state: 0 = free, 1 = operation in the multiplier, 2 = response offered
   int m_stage = 0;
   int m_ptr   = 0;

   fp_mul_arbiter #(.NUM_REQ(N), .ID_W(ID_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_a      (req_a),
      .req_b      (req_b),
      .mul_a      (mul_a),
      .mul_b      (mul_b),
      .mul_result (mul_result),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_result (rsp_result),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   always_comb begin
      req_a = '0;
      req_b = '0;
      for (int i = 0; i < N; i++) begin
         req_a[32*i +: 32] = va[i];
         req_b[32*i +: 32] = vb[i];
      end
   end

   // Truncating single-precision multiply; zero/denormal inputs give signed zero
   function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
      logic        s;
      int          ea, eb, e;
      logic [47:0] p;
      logic [22:0] m;
      s  = a[31] ^ b[31];
      ea = int'(a[30:23]);
      eb = int'(b[30:23]);
      if (ea == 0 || eb == 0) return {s, 31'd0};
      p = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
      e = ea + eb - 127;
      if (p[47]) begin
         m = p[46:24];
         e = e + 1;
      end else begin
         m = p[45:23];
      end
      if (e >= 255) return {s, 8'hFF, 23'd0};
      if (e <= 0)   return {s, 31'd0};
      return {s, e[7:0], m};
   endfunction

   function automatic logic [31:0] expect_prod(input logic [31:0] a, input logic [31:0] b);
`ifdef FP_MUL_ARB_SPECIAL_EN
      if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) begin
         if ((a[30:23] == 8'hFF && a[22:0] != 0) || (b[30:23] == 8'hFF && b[22:0] != 0) ||
             a[30:0] == 0 || b[30:0] == 0)
            return 32'h7FC0_0000;
         return {a[31] ^ b[31], 8'hFF, 23'd0};
      end
`endif
      return fmul(a, b);
   endfunction

   assign mul_result = fmul(mul_a, mul_b);

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model: predicts grants, handshake timing and pushes expected responses
   always @(negedge clk) begin
      int g;
      logic [N-1:0] exp_rdy;
      if (rst) begin
         m_stage = 0;
         m_ptr   = 0;
         exp_q.delete();
      end else begin
         g = -1;
         exp_rdy = '0;
         if (m_stage == 0) begin
            for (int k = 0; k < N; k++) begin
               if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
            end
            if (g >= 0) exp_rdy[g] = 1'b1;
         end
         chk("req_ready", 32'(req_ready), 32'(exp_rdy));
         chk("busy", 32'(busy), 32'(m_stage != 0));
         chk("rsp_valid", 32'(rsp_valid), 32'(m_stage == 2));
         case (m_stage)
            0: if (g >= 0) begin
                  exp_q.push_back('{id: ID_W'(g), res: expect_prod(va[g], vb[g])});
                  m_ptr   = (g + 1) % N;
                  m_stage = 1;
               end
            1: m_stage = 2;
            default: if (rsp_ready) m_stage = 0;
         endcase
      end
   end

   // Monitor: every offered response must match the oldest outstanding expectation
   always @(negedge clk) begin
      rsp_t e;
      if (!rst && rsp_valid) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_rsp: got id %0d result 0x%08h, expected no response", rsp_id, rsp_result);
         end else begin
            e = exp_q[0];
            chk("rsp_id", 32'(rsp_id), 32'(e.id));
            chk("rsp_result", rsp_result, e.res);
            if (rsp_ready) begin
               last_res[rsp_id] = rsp_result;
               void'(exp_q.pop_front());
            end
         end
      end
   end

   // Stimulus: directed scenarios followed by randomized traffic
   initial begin
      rst       = 1'b1;
      req_valid = '0;
      rsp_ready = 1'b1;
      for (int i = 0; i < N; i++) begin
         va[i] = '0;
         vb[i] = '0;
         last_res[i] = 32'hDEAD_BEEF;
      end
      repeat (3) tick();
      rst = 1'b0;
      chk("reset_mul_a", mul_a, 32'd0);
      chk("reset_mul_b", mul_b, 32'd0);
      chk("reset_rsp_id", 32'(rsp_id), 32'd0);
      chk("reset_rsp_result", rsp_result, 32'd0);
      chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);

      // round robin with all four requesters continuously valid
      va[0] = 32'h4000_0000; vb[0] = 32'h4040_0000;
      va[1] = 32'h3FC0_0000; vb[1] = 32'h3FC0_0000;
      va[2] = 32'hC000_0000; vb[2] = 32'h4040_0000;
      va[3] = 32'h0000_0000; vb[3] = 32'h40A0_0000;
      req_valid = 4'hF;
      repeat (15) tick();
      req_valid = '0;
      repeat (5) tick();
      chk("rr_res0", last_res[0], 32'h40C0_0000);
      chk("rr_res1", last_res[1], 32'h4010_0000);
      chk("rr_res2", last_res[2], 32'hC0C0_0000);
      chk("rr_res3", last_res[3], 32'h0000_0000);

      // single request from requester 1
      va[1] = 32'h4000_0000; vb[1] = 32'h4040_0000;
      req_valid = 4'b0010;
      tick();
      req_valid = '0;
      repeat (5) tick();
      chk("single_res1", last_res[1], 32'h40C0_0000);

      // backpressure: response held while rsp_ready is low, pending requests wait
      rsp_ready = 1'b0;
      req_valid = 4'b0101;
      repeat (9) tick();
      rsp_ready = 1'b1;
      repeat (6) tick();
      req_valid = '0;
      repeat (5) tick();

      // pointer wrap: requester 3 alone, then requester 0 alone
      req_valid = 4'b1000;
      tick();
      req_valid = 4'b0001;
      repeat (6) tick();
      req_valid = '0;
      repeat (5) tick();

      // reset while the operation is in EXEC: dropped, pointer back to 0
      req_valid = 4'b0100;
      tick();
      req_valid = '0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("midrst_busy", 32'(busy), 32'd0);
      repeat (4) tick();
      req_valid = 4'hF;
      tick();
      req_valid = '0;
      repeat (5) tick();

      // special operands
      va[1] = 32'h7F80_0000; vb[1] = 32'h0000_0000;
      req_valid = 4'b0010;
      tick();
      req_valid = '0;
      repeat (5) tick();
`ifdef FP_MUL_ARB_SPECIAL_EN
      chk("special_inf_x_zero", last_res[1], 32'h7FC0_0000);
`else
      chk("special_inf_x_zero", last_res[1], fmul(32'h7F80_0000, 32'h0000_0000));
`endif
      va[2] = 32'hFF80_0000; vb[2] = 32'h4000_0000;
      req_valid = 4'b0100;
      tick();
      req_valid = '0;
      repeat (5) tick();
`ifdef FP_MUL_ARB_SPECIAL_EN
      chk("special_ninf_x_two", last_res[2], 32'hFF80_0000);
`else
      chk("special_ninf_x_two", last_res[2], fmul(32'hFF80_0000, 32'h4000_0000));
`endif

      // randomized traffic: requests, operands and consumer stalls
      for (int c = 0; c < 400; c++) begin
         req_valid = N'($urandom);
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 3) == 0) begin
               va[i] = $urandom;
               vb[i] = $urandom;
            end
         end
         rsp_ready = ($urandom_range(0, 3) != 0);
         tick();
      end

      // drain with a bounded wait
      req_valid = '0;
      rsp_ready = 1'b1;
      for (int c = 0; c < 20; c++) begin
         if (exp_q.size() != 0 || busy) tick();
      end
      chk("drain_outstanding", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Global watchdog so the run always ends
   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
